// File: rtl/cacheline_adaptor.sv
// Cache line <-> memory burst adaptor: one line request becomes BEATS narrow beats.
// Latency: read_o/write_o one cycle after acceptance; resp_o the cycle after the last beat.
// Backpressure: memory paces beats with resp_i (gaps allowed); cache waits for resp_o.
module cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    localparam int BEATS  = LINE_WIDTH / BURST_WIDTH;
    localparam int OFFSET = $clog2(LINE_WIDTH / 8);
    localparam int CW     = $clog2(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'((64'd1 << OFFSET) - 64'd1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           count;
    logic [LINE_WIDTH-1:0]   wr_line;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    accept_rd;
    logic                    accept_wr;
    logic                    beat;

    always_comb begin
        state_nxt = state;
        accept_rd = 1'b0;
        accept_wr = 1'b0;
        beat      = 1'b0;
        case (state)
            IDLE: begin
                // A pending writeback must leave before the fill that replaces it.
                if (write_i) begin
                    accept_wr = 1'b1;
                    state_nxt = WR;
                end else if (read_i) begin
                    accept_rd = 1'b1;
                    state_nxt = RD;
                end
            end
            RD, WR: begin
                if (resp_i) begin
                    beat = 1'b1;
                    if (count == LAST_BEAT) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            addr_q  <= '0;
            wr_line <= '0;
            line_o  <= '0;
        end else begin
            if (accept_rd || accept_wr) begin
                count  <= '0;
                addr_q <= address_i;
            end else if (beat) begin
                // Wraps to zero on the last beat, which is unused until the next acceptance.
                count <= count + 1'b1;
            end
            if (accept_wr) begin
                wr_line <= line_i;
            end
            if (beat && (state == RD)) begin
                line_o[int'(count)*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
            end
        end
    end

    assign read_o    = (state == RD);
    assign write_o   = (state == WR);
    assign resp_o    = (state == DONE);
    assign address_o = addr_q & ADDR_MASK;
    assign burst_o   = (state == WR) ? wr_line[int'(count)*BURST_WIDTH +: BURST_WIDTH]
                                     : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: cycle table for read/write/priority, hand sequences
// for gapped reads, back-to-back writeback+fill and mid-burst reset.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int checks = 0;
    int errors = 0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        rsp;
        logic [63:0] bi;
        logic [31:0] ai;
        logic        e_rd;
        logic        e_wr;
        logic        e_resp;
        logic [63:0] e_bo;
        logic [31:0] e_ao;
    } vec_t;

    function automatic vec_t v(input logic rd, input logic wr, input logic rsp,
                               input logic [63:0] bi, input logic [31:0] ai,
                               input logic e_rd, input logic e_wr, input logic e_resp,
                               input logic [63:0] e_bo, input logic [31:0] e_ao);
        vec_t r;
        r.rd = rd; r.wr = wr; r.rsp = rsp; r.bi = bi; r.ai = ai;
        r.e_rd = e_rd; r.e_wr = e_wr; r.e_resp = e_resp; r.e_bo = e_bo; r.e_ao = e_ao;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle before sampling.
    task automatic drive(input logic rd, input logic wr, input logic rsp,
                         input logic [63:0] bi, input logic [31:0] ai);
        @(negedge clk);
        read_i = rd; write_i = wr; resp_i = rsp; burst_i = bi; address_i = ai;
        #1;
    endtask

    logic [63:0] a_bt[4], d_bt[4], b_bt[4], e_bt[4], f_bt[4], g_bt[4], h_bt[4];
    vec_t        vecs[22];
    logic [6:0]  pat;
    int          k;
    int          pulses;

    initial begin
        for (int i = 0; i < 4; i++) begin
            a_bt[i] = 64'hAAAA_0000_0000_00A0 + 64'(i);
            d_bt[i] = 64'hDDDD_0000_0000_00D0 + 64'(i);
            b_bt[i] = 64'hBBBB_0000_0000_00B0 + 64'(i);
            e_bt[i] = 64'hEEEE_0000_0000_00E0 + 64'(i);
            f_bt[i] = 64'hFFFF_0000_0000_00F0 + 64'(i);
            g_bt[i] = 64'h1111_0000_0000_0010 + 64'(i);
            h_bt[i] = 64'h2222_0000_0000_0020 + 64'(i);
        end

        //             rd wr rs bi                      ai            erd ewr ers ebo      eao
        vecs[0]  = v(0, 0, 0, 64'h0,                 32'h0,        0, 0, 0, 64'h0,    32'h0);
        vecs[1]  = v(1, 0, 0, 64'h0,                 32'h0000_1234, 0, 0, 0, 64'h0,   32'h0);
        vecs[2]  = v(0, 0, 1, a_bt[0],               32'h0,        1, 0, 0, 64'h0,    32'h0000_1220);
        vecs[3]  = v(0, 0, 1, a_bt[1],               32'h0,        1, 0, 0, 64'h0,    32'h0000_1220);
        vecs[4]  = v(0, 0, 1, a_bt[2],               32'h0,        1, 0, 0, 64'h0,    32'h0000_1220);
        vecs[5]  = v(0, 0, 1, a_bt[3],               32'h0,        1, 0, 0, 64'h0,    32'h0000_1220);
        vecs[6]  = v(1, 0, 0, 64'h0,                 32'h0000_5555, 0, 0, 1, 64'h0,   32'h0000_1220);
        vecs[7]  = v(0, 0, 0, 64'h0,                 32'h0,        0, 0, 0, 64'h0,    32'h0000_1220);
        vecs[8]  = v(0, 1, 0, 64'h0,                 32'h0000_ABCD, 0, 0, 0, 64'h0,   32'h0000_1220);
        vecs[9]  = v(0, 0, 1, 64'h0,                 32'h0,        0, 1, 0, d_bt[0],  32'h0000_ABC0);
        vecs[10] = v(0, 0, 0, 64'h0,                 32'h0,        0, 1, 0, d_bt[1],  32'h0000_ABC0);
        vecs[11] = v(0, 0, 1, 64'h0,                 32'h0,        0, 1, 0, d_bt[1],  32'h0000_ABC0);
        vecs[12] = v(0, 0, 1, 64'h0,                 32'h0,        0, 1, 0, d_bt[2],  32'h0000_ABC0);
        vecs[13] = v(0, 0, 1, 64'h0,                 32'h0,        0, 1, 0, d_bt[3],  32'h0000_ABC0);
        vecs[14] = v(0, 0, 0, 64'h0,                 32'h0,        0, 0, 1, 64'h0,    32'h0000_ABC0);
        vecs[15] = v(1, 1, 0, 64'h0,                 32'h0000_0100, 0, 0, 0, 64'h0,   32'h0000_ABC0);
        vecs[16] = v(0, 0, 1, 64'h0,                 32'h0,        0, 1, 0, d_bt[0],  32'h0000_0100);
        vecs[17] = v(0, 0, 1, 64'h0,                 32'h0,        0, 1, 0, d_bt[1],  32'h0000_0100);
        vecs[18] = v(0, 0, 1, 64'h0,                 32'h0,        0, 1, 0, d_bt[2],  32'h0000_0100);
        vecs[19] = v(0, 0, 1, 64'h0,                 32'h0,        0, 1, 0, d_bt[3],  32'h0000_0100);
        vecs[20] = v(0, 0, 0, 64'h0,                 32'h0,        0, 0, 1, 64'h0,    32'h0000_0100);
        vecs[21] = v(0, 0, 1, 64'hDEAD_BEEF_DEAD_BEEF, 32'h0,      0, 0, 0, 64'h0,    32'h0000_0100);

        rst = 1'b0; read_i = 0; write_i = 0; resp_i = 0; burst_i = '0; address_i = '0;
        line_i = {d_bt[3], d_bt[2], d_bt[1], d_bt[0]};
        #12;
        chk("reset read_o",    256'(read_o),    256'(0));
        chk("reset write_o",   256'(write_o),   256'(0));
        chk("reset resp_o",    256'(resp_o),    256'(0));
        chk("reset line_o",    line_o,          256'(0));
        chk("reset burst_o",   256'(burst_o),   256'(0));
        chk("reset address_o", 256'(address_o), 256'(0));
        @(negedge clk);
        rst = 1'b1;

        // Table: read, write with a gap, simultaneous read+write, resp_i in IDLE.
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].rsp, vecs[i].bi, vecs[i].ai);
            chk($sformatf("vec%0d read_o", i),    256'(read_o),    256'(vecs[i].e_rd));
            chk($sformatf("vec%0d write_o", i),   256'(write_o),   256'(vecs[i].e_wr));
            chk($sformatf("vec%0d resp_o", i),    256'(resp_o),    256'(vecs[i].e_resp));
            chk($sformatf("vec%0d address_o", i), 256'(address_o), 256'(vecs[i].e_ao));
            if (vecs[i].e_wr) begin
                chk($sformatf("vec%0d burst_o", i), 256'(burst_o), 256'(vecs[i].e_bo));
            end
        end
        drive(0, 0, 0, 64'h0, 32'h0);
        chk("table line_o kept", line_o, {a_bt[3], a_bt[2], a_bt[1], a_bt[0]});

        // Gapped read: resp_i = 1,0,0,1,1,0,1.
        pat = 7'b1011001;
        k = 0;
        drive(1, 0, 0, 64'h0, 32'h2000_003F);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, pat[i], pat[i] ? b_bt[k] : 64'h5A5A_5A5A_5A5A_5A5A, 32'h0);
            chk($sformatf("gap cyc%0d read_o", i), 256'(read_o), 256'(1));
            chk($sformatf("gap cyc%0d resp_o", i), 256'(resp_o), 256'(0));
            if (pat[i]) k++;
        end
        drive(0, 0, 0, 64'h0, 32'h0);
        chk("gap resp_o",    256'(resp_o),    256'(1));
        chk("gap read_o",    256'(read_o),    256'(0));
        chk("gap address_o", 256'(address_o), 256'(32'h2000_0020));
        chk("gap line_o",    line_o,          {b_bt[3], b_bt[2], b_bt[1], b_bt[0]});
        drive(0, 0, 0, 64'h0, 32'h0);
        chk("gap resp_o one cycle", 256'(resp_o), 256'(0));

        // Writeback then fill issued the cycle after resp_o.
        line_i = {e_bt[3], e_bt[2], e_bt[1], e_bt[0]};
        pulses = 0;
        for (int c = 0; c < 13; c++) begin
            if (c == 0)                 drive(0, 1, 0, 64'h0, 32'h3000_0040);
            else if (c >= 1 && c <= 4)  drive(0, 0, 1, 64'h0, 32'h0);
            else if (c == 6)            drive(1, 0, 0, 64'h0, 32'h3000_0080);
            else if (c >= 7 && c <= 10) drive(0, 0, 1, f_bt[c-7], 32'h0);
            else                        drive(0, 0, 0, 64'h0, 32'h0);
            if (resp_o) pulses++;
            if (c >= 1 && c <= 4) begin
                chk($sformatf("b2b wr burst_o%0d", c-1), 256'(burst_o), 256'(e_bt[c-1]));
                chk($sformatf("b2b wr address_o%0d", c-1), 256'(address_o), 256'(32'h3000_0040));
            end
            if (c == 5) chk("b2b wr write_o drops", 256'({write_o, resp_o}), 256'(2'b01));
            if (c >= 7 && c <= 10) begin
                chk($sformatf("b2b rd read_o%0d", c-7), 256'(read_o), 256'(1));
                chk($sformatf("b2b rd address_o%0d", c-7), 256'(address_o), 256'(32'h3000_0080));
            end
            if (c == 11) chk("b2b rd resp_o", 256'(resp_o), 256'(1));
        end
        chk("b2b resp pulses", 256'(pulses), 256'(2));
        chk("b2b line_o", line_o, {f_bt[3], f_bt[2], f_bt[1], f_bt[0]});

        // Reset after two read beats, then a fresh read.
        drive(1, 0, 0, 64'h0, 32'h4000_0000);
        drive(0, 0, 1, g_bt[0], 32'h0);
        drive(0, 0, 1, g_bt[1], 32'h0);
        drive(0, 0, 0, 64'h0, 32'h0);
        chk("pre-reset read_o", 256'(read_o), 256'(1));
        #1 rst = 1'b0;
        #1;
        chk("mid reset read_o",    256'(read_o),    256'(0));
        chk("mid reset write_o",   256'(write_o),   256'(0));
        chk("mid reset resp_o",    256'(resp_o),    256'(0));
        chk("mid reset line_o",    line_o,          256'(0));
        chk("mid reset burst_o",   256'(burst_o),   256'(0));
        chk("mid reset address_o", 256'(address_o), 256'(0));
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 0, 64'h0, 32'h4000_0060);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, h_bt[i], 32'h0);
            chk($sformatf("post-reset read_o%0d", i), 256'(read_o), 256'(1));
        end
        drive(0, 0, 0, 64'h0, 32'h0);
        chk("post-reset resp_o",    256'(resp_o),    256'(1));
        chk("post-reset address_o", 256'(address_o), 256'(32'h4000_0060));
        chk("post-reset line_o",    line_o,          {h_bt[3], h_bt[2], h_bt[1], h_bt[0]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
